// File: rtl/bcd_if.sv
// bcd_if: trigger-side controls and display-side results of the BCD digit chain.
interface bcd_if #(parameter int DIGITS = 6);
    logic                inc_clk;
    logic                ref_clk;
    logic [DIGITS-1:0]   digit_sel;
    logic                clear;
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic                busy;
    logic                overflow;
    modport master (
        output inc_clk, ref_clk, digit_sel, clear,
        input  value, value_valid, busy, overflow
    );
    modport slave (
        input  inc_clk, ref_clk, digit_sel, clear,
        output value, value_valid, busy, overflow
    );
endinterface

// File: rtl/bcd_digit_chain.sv
// bcd_digit_chain: BCD counter with one-digit-per-clock carry ripple and snapshot display register.
module bcd_digit_chain #(parameter int DIGITS = 6) (
    input logic clk,
    input logic reset,
    bcd_if.slave bus
);
    logic [4*DIGITS-1:0] digits, nxt;
    logic [DIGITS-1:0]   carry, cout;
    logic                ref_q;
    // carry[0] never sets, so digit 0 only ever sees its own increment
    for (genvar i = 0; i < DIGITS; i++) begin : g_d
        logic [4:0] sum;
        assign sum = {1'b0, digits[4*i +: 4]} + 5'(bus.inc_clk & bus.digit_sel[i]) + 5'(carry[i]);
        assign cout[i] = sum >= 5'd10;
        assign nxt[4*i +: 4] = cout[i] ? 4'(sum - 5'd10) : sum[3:0];
    end
    assign bus.busy = |carry;
    always_ff @(posedge clk) begin
        if (reset) begin
            digits          <= '0;
            carry           <= '0;
            ref_q           <= 1'b0;
            bus.value       <= '0;
            bus.value_valid <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            ref_q           <= bus.ref_clk;
            bus.value_valid <= ref_q;
            if (bus.ref_clk) bus.value <= digits;
            if (bus.clear) begin
                digits       <= '0;
                carry        <= '0;
                bus.overflow <= 1'b0;
            end else begin
                digits <= nxt;
                carry  <= {cout[DIGITS-2:0], 1'b0};
                if (cout[DIGITS-1]) bus.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/bcd_digit_chain.md
Name: bcd_digit_chain

Overview:
- Downstream consumer of the input trigger counter's pulses. Holds a DIGITS-wide BCD counter; each inc_clk pulse increments every digit whose trigger bit is held.
- Carries ripple one digit per clock, so a full carry chain settles inside the upstream 10-cycle Calculation window.
- On ref_clk the settled digits are captured into a stable display register for the 7-segment / output stage.

Parameters:
- DIGITS, 6, number of BCD digits; must match the trigger vector width; 2..9 so the ripple fits the 10-cycle window.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- inc_clk  input  1  one-cycle increment pulse from the trigger counter.
- ref_clk  input  1  one-cycle refresh pulse from the trigger counter.
- digit_sel  input  DIGITS  per-digit increment enable (same vector as the debounced triggers); bit i = digit i, bit 0 = least significant.
- clear  input  1  synchronous clear of the counter.
- value  output  4*DIGITS  displayed BCD value; digit i at bits [4i+3:4i].
- value_valid  output  1  one-cycle pulse, one cycle after value updates.
- busy  output  1  high while any carry is pending.
- overflow  output  1  sticky; set on carry out of the top digit.

Behaviour:
- Internal state: digit[i] (4 bit, always 0..9) and carry[i] pending flags for i = 1..DIGITS-1.
- Reset (synchronous, highest priority) clears:
  - digits, carries, value, value_valid, overflow;
  - busy reads 0 the next cycle.
- Priority: reset > clear > normal update.
- clear zeroes digits, carries and overflow. value and value_valid are not affected.
- Per-cycle update for each digit i:
  - own = inc_clk & digit_sel[i]
  - cin = carry[i] (0 for i = 0)
  - sum = digit[i] + own + cin, range 0..11
  - if sum >= 10: digit[i] <= sum - 10 and carry[i+1] <= 1
  - otherwise: digit[i] <= sum and carry[i+1] <= 0
- carry[i] is consumed (cleared) in the cycle it is applied unless it is re-generated by the digit below.
- Ripple latency: a carry out of digit k reaches digit k+1 on the next edge. The worst case is DIGITS-1 cycles after the inc_clk edge, plus 1 cycle for the overflow flag.
- Top digit: sum >= 10 wraps it modulo 10 and sets overflow on the same edge. Overflow stays set until reset or clear.
- inc_clk arriving while busy is legal: own and cin add together. Nothing is dropped and no extra stall is inserted.
- busy = OR of all carry flags (combinational from registers).
- Snapshot: on a ref_clk cycle, value <= the concatenation of the digit registers as they stand before that edge's update. value_valid is 1 in the cycle after value changes and 0 otherwise.
- ref_clk and inc_clk in the same cycle: the snapshot takes the pre-increment digits.
- ref_clk while busy: the snapshot is taken anyway, with no deferral. Keeping ref_clk outside the ripple window is the upstream timer's job.
- No other outputs are registered beyond those listed. All outputs are 0 after reset.

Test Plan:
1. Assert reset 2 cycles, then idle 5 cycles -> value=0, busy=0, overflow=0, value_valid=0.
2. digit_sel=000001; 12 inc_clk pulses 20 cycles apart, each followed 10 cycles later by ref_clk -> final value=24'h000012; value_valid pulses 12 times.
3. digit_sel=111111, 9 pulses (-> 24'h999999, busy never high); then digit_sel=000001, one pulse -> busy high 5 cycles, digits all 0, overflow=1 at cycle 6; ref_clk at +10 gives value=0.
4. Digits 00 09 (d1=0, d0=9); cycle 0 inc_clk with sel=000011; cycle 1 inc_clk with sel=000010 -> d1=3, d0=0 (value 24'h000030 after ref_clk).
5. Digits 000009, sel=000001; inc_clk and ref_clk on the same cycle -> value=24'h000009. A second ref_clk 10 cycles later -> value=24'h000010.
6. Start a 999999+1 ripple; assert reset at cycle 2 of the ripple -> busy=0, digits=0, overflow=0 next cycle; no late carry appears afterwards.
   - Repeat with clear instead -> same result, but value keeps its last snapshot.
